// File: rtl/noc_traffic_node.sv
// ---------------------------------------------------------------------------
// noc_traffic_node
//
// NoC test endpoint. A burst generator sends PKT_COUNT packets to the
// router at (DEST_X_ID, DEST_Y_ID). Each packet is a header, PAYLOAD_FLITS
// payload flits and a tail. GAP_CYCLES idle cycles follow each tail
// except the last. A receive side counts packets (tails) and remembers
// the source of the last header. When NOC_TRAFFIC_CHECK_EN is defined it
// also counts protocol and payload-index errors.
//
// Build option:
//   NOC_TRAFFIC_CHECK_EN  defined   -> full receive checking, rx_err_count live
//                         undefined -> no checking logic, rx_err_count = 0
//
// Handshake: a flit moves on any cycle where valid && ready. The sender
// keeps valid, flit and markers stable until that cycle. The receiver
// holds ready high whenever it is out of reset.
//
// Ports:
//   noc_clk, noc_rst_n       clock, asynchronous active-low reset
//   send_start               one-cycle pulse, starts a burst (ignored when busy)
//   send_busy / send_done    burst in progress / one-cycle end-of-burst pulse
//   sender_valid/ready/flit  flit stream toward the router,
//   sender_is_header/_tail     plus the header and tail markers
//   receive_valid/ready/flit flit stream from the router,
//   receive_is_header/_tail    plus the header and tail markers
//   rx_pkt_count             tails received (saturating)
//   rx_err_count             errors detected (saturating)
//   rx_last_src_x/_y         source of the last accepted header
//   dbg_tx_state/dbg_rx_state  current sender and receiver FSM states
//
// Flit format (bits from the MSB down): 4-bit start marker, source X,
// source Y, destination X, destination Y, 16 zero bits for the type, order
// and length fields, 4-bit end marker, zero pad.
// ---------------------------------------------------------------------------
`ifndef Noc_Data_Width
`define Noc_Data_Width 64
`endif
`ifndef Noc_ID_X_Width
`define Noc_ID_X_Width 4
`endif
`ifndef Noc_ID_Y_Width
`define Noc_ID_Y_Width 4
`endif

module noc_traffic_node #(
    parameter logic [`Noc_ID_X_Width-1:0] X_ID      = '0,
    parameter logic [`Noc_ID_Y_Width-1:0] Y_ID      = '0,
    parameter logic [`Noc_ID_X_Width-1:0] DEST_X_ID = '0,
    parameter logic [`Noc_ID_Y_Width-1:0] DEST_Y_ID = '0,
    parameter int PAYLOAD_FLITS = 4,
    parameter int PKT_COUNT     = 8,
    parameter int GAP_CYCLES    = 0
) (
    input  logic                          noc_clk,
    input  logic                          noc_rst_n,
    input  logic                          send_start,
    output logic                          send_busy,
    output logic                          send_done,
    output logic                          sender_valid,
    input  logic                          sender_ready,
    output logic [`Noc_Data_Width-1:0]    sender_flit,
    output logic                          sender_is_header,
    output logic                          sender_is_tail,
    input  logic                          receive_valid,
    output logic                          receive_ready,
    input  logic [`Noc_Data_Width-1:0]    receive_flit,
    input  logic                          receive_is_header,
    input  logic                          receive_is_tail,
    output logic [15:0]                   rx_pkt_count,
    output logic [15:0]                   rx_err_count,
    output logic [`Noc_ID_X_Width-1:0]    rx_last_src_x,
    output logic [`Noc_ID_Y_Width-1:0]    rx_last_src_y,
    output logic [2:0]                    dbg_tx_state,
    output logic                          dbg_rx_state
);

    localparam int DW     = `Noc_Data_Width;
    localparam int XW     = `Noc_ID_X_Width;
    localparam int YW     = `Noc_ID_Y_Width;
    localparam int MW     = 4;
    localparam int POS_H  = DW - MW;
    localparam int POS_X  = POS_H - XW;
    localparam int POS_Y  = POS_X - YW;
    localparam int POS_DX = POS_Y - XW;
    localparam int POS_DY = POS_DX - YW;
    localparam int POS_E  = POS_DY - 16 - MW;

    localparam logic [MW-1:0] HEAD_H = 4'hA;
    localparam logic [MW-1:0] HEAD_E = 4'h5;
    localparam logic [MW-1:0] TAIL_H = 4'hC;
    localparam logic [MW-1:0] TAIL_E = 4'h3;

    localparam logic [15:0] PF     = 16'(PAYLOAD_FLITS);
    localparam logic [7:0]  K_LAST = 8'(PAYLOAD_FLITS - 1);
    localparam logic [15:0] P_LAST = 16'(PKT_COUNT - 1);
    localparam logic [7:0]  G_LAST = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    localparam logic [2:0] TX_IDLE = 3'd0;
    localparam logic [2:0] TX_HEAD = 3'd1;
    localparam logic [2:0] TX_DATA = 3'd2;
    localparam logic [2:0] TX_TAIL = 3'd3;
    localparam logic [2:0] TX_GAP  = 3'd4;

    localparam logic [0:0] RX_WAIT = 1'b0;
    localparam logic [0:0] RX_BODY = 1'b1;

    // Header and tail share one layout and differ only in the markers.
    function automatic logic [DW-1:0] ctrl_flit(input logic [MW-1:0] mh,
                                                input logic [MW-1:0] me);
        logic [DW-1:0] f;
        f = '0;
        f[POS_H  +: MW] = mh;
        f[POS_X  +: XW] = X_ID;
        f[POS_Y  +: YW] = Y_ID;
        f[POS_DX +: XW] = DEST_X_ID;
        f[POS_DY +: YW] = DEST_Y_ID;
        f[POS_E  +: MW] = me;
        return f;
    endfunction

    function automatic logic [DW-1:0] data_flit(input logic [15:0] p,
                                                input logic [15:0] k);
        logic [DW-1:0] f;
        f = '0;
        f[31:16] = p;
        f[15:0]  = k;
        return f;
    endfunction

    // ------------------------------------------------------------------
    // Sender. The output registers always hold the flit that is presented
    // now. They are reloaded only on an accepting edge, which keeps the
    // flit stable while the router stalls.
    // ------------------------------------------------------------------
    logic [2:0]  tx_state;
    logic [15:0] tx_pkt;
    logic [7:0]  tx_k;
    logic [7:0]  tx_gap;
    logic        tx_accept;

    assign tx_accept = sender_valid && sender_ready;

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            tx_state         <= TX_IDLE;
            tx_pkt           <= '0;
            tx_k             <= '0;
            tx_gap           <= '0;
            sender_valid     <= 1'b0;
            sender_flit      <= '0;
            sender_is_header <= 1'b0;
            sender_is_tail   <= 1'b0;
            send_busy        <= 1'b0;
            send_done        <= 1'b0;
        end else begin
            send_done <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (send_start) begin
                        tx_state         <= TX_HEAD;
                        tx_pkt           <= '0;
                        send_busy        <= 1'b1;
                        sender_valid     <= 1'b1;
                        sender_is_header <= 1'b1;
                        sender_flit      <= ctrl_flit(HEAD_H, HEAD_E);
                    end
                end
                TX_HEAD: begin
                    if (tx_accept) begin
                        tx_state         <= TX_DATA;
                        tx_k             <= '0;
                        sender_is_header <= 1'b0;
                        sender_flit      <= data_flit(tx_pkt, 16'd0);
                    end
                end
                TX_DATA: begin
                    if (tx_accept) begin
                        if (tx_k == K_LAST) begin
                            tx_state       <= TX_TAIL;
                            sender_is_tail <= 1'b1;
                            sender_flit    <= ctrl_flit(TAIL_H, TAIL_E);
                        end else begin
                            tx_k        <= tx_k + 8'd1;
                            sender_flit <= data_flit(tx_pkt, {8'd0, tx_k + 8'd1});
                        end
                    end
                end
                TX_TAIL: begin
                    if (tx_accept) begin
                        sender_is_tail <= 1'b0;
                        if (tx_pkt == P_LAST) begin
                            tx_state     <= TX_IDLE;
                            sender_valid <= 1'b0;
                            sender_flit  <= '0;
                            send_busy    <= 1'b0;
                            send_done    <= 1'b1;
                        end else begin
                            tx_pkt <= tx_pkt + 16'd1;
                            if (GAP_CYCLES == 0) begin
                                tx_state         <= TX_HEAD;
                                sender_is_header <= 1'b1;
                                sender_flit      <= ctrl_flit(HEAD_H, HEAD_E);
                            end else begin
                                tx_state     <= TX_GAP;
                                tx_gap       <= '0;
                                sender_valid <= 1'b0;
                                sender_flit  <= '0;
                            end
                        end
                    end
                end
                TX_GAP: begin
                    if (tx_gap == G_LAST) begin
                        tx_state         <= TX_HEAD;
                        sender_valid     <= 1'b1;
                        sender_is_header <= 1'b1;
                        sender_flit      <= ctrl_flit(HEAD_H, HEAD_E);
                    end else begin
                        tx_gap <= tx_gap + 8'd1;
                    end
                end
                default: begin
                    tx_state     <= TX_IDLE;
                    sender_valid <= 1'b0;
                    send_busy    <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [0:0] rx_state;
    logic [0:0] rx_state_next;
    logic       rx_fire;
    logic       rx_latch;
    logic       rx_pkt_hit;
    logic       unused_flit;

    assign rx_fire     = receive_valid && receive_ready;
    assign unused_flit = ^receive_flit;

`ifdef NOC_TRAFFIC_CHECK_EN
    logic [15:0] rx_k;
    logic [15:0] rx_k_next;
    logic        rx_err_hit;
    logic [15:0] rx_err_q;

    always_comb begin
        rx_latch      = 1'b0;
        rx_pkt_hit    = 1'b0;
        rx_err_hit    = 1'b0;
        rx_state_next = rx_state;
        rx_k_next     = rx_k;
        if (rx_fire) begin
            if (receive_is_header && receive_is_tail) begin
                rx_err_hit = 1'b1;                  // malformed flit is dropped
            end else if (rx_state == RX_WAIT) begin
                if (receive_is_header) begin
                    rx_latch      = 1'b1;
                    rx_k_next     = '0;
                    rx_state_next = RX_BODY;
                end else begin
                    rx_err_hit = 1'b1;              // stray flit is dropped
                end
            end else if (receive_is_header) begin
                rx_err_hit = 1'b1;                  // packet restarts here
                rx_latch   = 1'b1;
                rx_k_next  = '0;
            end else if (receive_is_tail) begin
                rx_pkt_hit    = 1'b1;               // short packets still count
                rx_err_hit    = (rx_k != PF);
                rx_state_next = RX_WAIT;
            end else begin
                rx_err_hit = (receive_flit[15:0] != rx_k);
                rx_k_next  = rx_k + 16'd1;
            end
        end
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            rx_k     <= '0;
            rx_err_q <= '0;
        end else begin
            rx_k <= rx_k_next;
            if (rx_err_hit && (rx_err_q != 16'hFFFF))
                rx_err_q <= rx_err_q + 16'd1;
        end
    end

    assign rx_err_count = rx_err_q;
`else
    always_comb begin
        rx_latch      = 1'b0;
        rx_pkt_hit    = 1'b0;
        rx_state_next = rx_state;
        if (rx_fire) begin
            if (receive_is_header) begin
                rx_latch      = 1'b1;
                rx_state_next = RX_BODY;
            end else if (receive_is_tail) begin
                rx_pkt_hit    = 1'b1;
                rx_state_next = RX_WAIT;
            end
        end
    end

    assign rx_err_count = '0;
`endif

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            rx_state      <= RX_WAIT;
            receive_ready <= 1'b0;
            rx_pkt_count  <= '0;
            rx_last_src_x <= '0;
            rx_last_src_y <= '0;
        end else begin
            receive_ready <= 1'b1;
            rx_state      <= rx_state_next;
            if (rx_latch) begin
                rx_last_src_x <= receive_flit[POS_X +: XW];
                rx_last_src_y <= receive_flit[POS_Y +: YW];
            end
            if (rx_pkt_hit && (rx_pkt_count != 16'hFFFF))
                rx_pkt_count <= rx_pkt_count + 16'd1;
        end
    end

    assign dbg_tx_state = tx_state;
    assign dbg_rx_state = rx_state;

endmodule

// File: tb/tb_noc_traffic_node.sv
// ---------------------------------------------------------------------------
// tb_noc_traffic_node
//
// Bench for noc_traffic_node (PAYLOAD_FLITS=4, PKT_COUNT=2, GAP_CYCLES=0,
// source (1,2), destination (3,0)). The sender can be looped back into the
// receiver, or the receiver can be fed directly from driver tasks.
// Expected sender flits are pushed when a burst is started. Expected
// receive counters come from a packet-rule model. Both are popped and
// compared by monitors on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_noc_traffic_node;
    localparam int DW = 64;
    localparam int PF = 4;
    localparam int PC = 2;
    localparam int W  = DW + 2;
`ifdef NOC_TRAFFIC_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic          send_start, send_busy, send_done;
    logic          sender_valid, sender_ready, sender_is_header, sender_is_tail;
    logic [DW-1:0] sender_flit;
    logic          receive_ready;
    logic [15:0]   rx_pkt_count, rx_err_count;
    logic [3:0]    rx_last_src_x, rx_last_src_y;
    logic [2:0]    dbg_tx_state;
    logic          dbg_rx_state;

    logic          loop_en;
    logic          inj_valid, inj_h, inj_t;
    logic [DW-1:0] inj_flit;
    logic          rx_valid, rx_h, rx_t;
    logic [DW-1:0] rx_flit;

    assign rx_valid = loop_en ? (sender_valid && sender_ready) : inj_valid;
    assign rx_h     = loop_en ? sender_is_header : inj_h;
    assign rx_t     = loop_en ? sender_is_tail   : inj_t;
    assign rx_flit  = loop_en ? sender_flit      : inj_flit;

    noc_traffic_node #(
        .X_ID(4'd1), .Y_ID(4'd2), .DEST_X_ID(4'd3), .DEST_Y_ID(4'd0),
        .PAYLOAD_FLITS(PF), .PKT_COUNT(PC), .GAP_CYCLES(0)
    ) dut (
        .noc_clk(clk), .noc_rst_n(rst_n),
        .send_start(send_start), .send_busy(send_busy), .send_done(send_done),
        .sender_valid(sender_valid), .sender_ready(sender_ready),
        .sender_flit(sender_flit), .sender_is_header(sender_is_header),
        .sender_is_tail(sender_is_tail),
        .receive_valid(rx_valid), .receive_ready(receive_ready),
        .receive_flit(rx_flit), .receive_is_header(rx_h), .receive_is_tail(rx_t),
        .rx_pkt_count(rx_pkt_count), .rx_err_count(rx_err_count),
        .rx_last_src_x(rx_last_src_x), .rx_last_src_y(rx_last_src_y),
        .dbg_tx_state(dbg_tx_state), .dbg_rx_state(dbg_rx_state)
    );

    // scoreboard state
    int n_checks = 0;
    int n_fail   = 0;
    int n_accepted = 0;
    int ready_mode = 0;
    logic [W-1:0] exp_q[$];
    logic [39:0]  rx_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] ctl(input logic [3:0] mh, input logic [3:0] me,
                                          input logic [3:0] x, input logic [3:0] y,
                                          input logic [3:0] dx, input logic [3:0] dy);
        return {mh, x, y, dx, dy, 16'h0, me, 24'h0};
    endfunction

    function automatic logic [DW-1:0] pay(input int p, input int k);
        logic [15:0] p16, k16;
        p16 = 16'(p);
        k16 = 16'(k);
        return {32'h0, p16, k16};
    endfunction

    task automatic push_burst();
        for (int p = 0; p < PC; p++) begin
            exp_q.push_back({2'b10, ctl(4'hA, 4'h5, 4'd1, 4'd2, 4'd3, 4'd0)});
            for (int k = 0; k < PF; k++) exp_q.push_back({2'b00, pay(p, k)});
            exp_q.push_back({2'b01, ctl(4'hC, 4'h3, 4'd1, 4'd2, 4'd3, 4'd0)});
        end
    endtask

    // receive model: packet rules applied flit by flit
    int m_pkt, m_err, m_k;
    bit m_in;
    logic [3:0] m_x, m_y;

    task automatic model_reset();
        m_pkt = 0; m_err = 0; m_k = 0; m_in = 0; m_x = '0; m_y = '0;
    endtask

    task automatic model_flit(input logic h, input logic t, input logic [DW-1:0] f);
        int errs;
        errs = 0;
        if (CHK) begin
            if (h && t) errs = 1;
            else if (h) begin
                if (m_in) errs = 1;
                m_x = f[59:56]; m_y = f[55:52]; m_k = 0; m_in = 1;
            end else if (!m_in) errs = 1;
            else if (t) begin
                if (m_k != PF) errs = 1;
                if (m_pkt < 65535) m_pkt++;
                m_in = 0;
            end else begin
                if (f[15:0] != 16'(m_k)) errs = 1;
                m_k++;
            end
        end else begin
            if (h) begin m_x = f[59:56]; m_y = f[55:52]; end
            else if (t && m_pkt < 65535) m_pkt++;
        end
        if (errs != 0 && m_err < 65535) m_err++;
    endtask

    // sender monitor
    always @(negedge clk) begin : tx_monitor
        logic [W-1:0] cur, e, held;
        bit held_v;
        if (!rst_n) begin
            exp_q.delete();
            held_v = 1'b0;
        end else if (sender_valid) begin
            cur = {sender_is_header, sender_is_tail, sender_flit};
            if (held_v) check("tx_hold_stable", cur, held);
            if (sender_ready) begin
                n_accepted++;
                held_v = 1'b0;
                check("tx_flit_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("tx_flit", cur, e);
                end
            end else begin
                held   = cur;
                held_v = 1'b1;
            end
        end
    end

    // receiver monitor
    always @(negedge clk) begin : rx_monitor
        logic [39:0] e;
        if (!rst_n) begin
            rx_q.delete();
            model_reset();
        end else begin
            if (rx_q.size() > 0) begin
                e = rx_q.pop_front();
                check("rx_pkt_count", rx_pkt_count, e[39:24]);
                check("rx_err_count", rx_err_count, e[23:8]);
                check("rx_last_src", {rx_last_src_x, rx_last_src_y}, e[7:0]);
            end
            if (rx_valid && receive_ready) begin
                model_flit(rx_h, rx_t, rx_flit);
                rx_q.push_back({16'(m_pkt), 16'(m_err), m_x, m_y});
            end
        end
    end

    // ready driver: 0 = held high, 1 = toggling, 2 = random
    initial begin
        sender_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       sender_ready = 1'b1;
                1:       sender_ready = ~sender_ready;
                default: sender_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // driver tasks (all start and end 1 ns after a rising edge)
    task automatic start_pulse();
        send_start = 1'b1;
        @(posedge clk); #1;
        send_start = 1'b0;
    endtask

    task automatic wait_done(input int exp_cyc, input bit first);
        int cyc;
        bit seen;
        cyc = 0; seen = 0;
        while (!seen && cyc < 400) begin
            @(negedge clk); cyc++;
            if (first && cyc == 1) begin
                check("header_after_start", {sender_valid, sender_is_header}, 2'b11);
                check("busy_after_start", send_busy, 1'b1);
            end
            if (send_done) begin
                seen = 1;
                check("busy_falls_with_done", send_busy, 1'b0);
            end
        end
        check("send_done_seen", seen, 1'b1);
        if (exp_cyc > 0) check("send_done_cycle", cyc, exp_cyc);
        check("exp_q_drained", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_one_cycle", send_done, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", receive_ready, 1'b1);
    endtask

    task automatic rx_send(input logic h, input logic t, input logic [DW-1:0] f);
        inj_h = h; inj_t = t; inj_flit = f; inj_valid = 1'b1;
        @(posedge clk); #1;
        inj_valid = 1'b0; inj_h = 1'b0; inj_t = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin : watchdog
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : main
        int base;
        int r;
        logic [3:0] rx4, ry4;
        rst_n = 1'b0; send_start = 1'b0; loop_en = 1'b1;
        inj_valid = 1'b0; inj_h = 1'b0; inj_t = 1'b0; inj_flit = '0;
        model_reset();

        // reset values
        repeat (2) @(negedge clk);
        check("rst_sender_valid", sender_valid, 1'b0);
        check("rst_sender_flit", sender_flit, 64'h0);
        check("rst_is_header", sender_is_header, 1'b0);
        check("rst_is_tail", sender_is_tail, 1'b0);
        check("rst_busy", send_busy, 1'b0);
        check("rst_done", send_done, 1'b0);
        check("rst_receive_ready", receive_ready, 1'b0);
        check("rst_pkt_count", rx_pkt_count, 16'h0);
        check("rst_err_count", rx_err_count, 16'h0);
        check("rst_src", {rx_last_src_x, rx_last_src_y}, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_release", receive_ready, 1'b1);

        // full-rate loopback burst
        push_burst(); start_pulse(); wait_done(13, 1);
        idle(2);
        check("loop_pkt_count", rx_pkt_count, 16'd2);
        check("loop_err_count", rx_err_count, 16'd0);
        check("loop_src", {rx_last_src_x, rx_last_src_y}, 8'h12);

        // toggling ready
        ready_mode = 1; base = n_accepted;
        push_burst(); start_pulse(); wait_done(-1, 1);
        check("toggle_accepted", n_accepted - base, PC * (PF + 2));

        // random ready, plus a send_start that must be ignored mid-burst
        ready_mode = 2; base = n_accepted;
        push_burst(); start_pulse();
        idle(3); start_pulse();
        wait_done(-1, 0);
        idle(20);
        check("ignored_start_idle", sender_valid, 1'b0);
        check("random_accepted", n_accepted - base, PC * (PF + 2));
        ready_mode = 0; idle(1);

        // reset in the middle of a packet
        push_burst(); start_pulse(); idle(3);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", sender_valid, 1'b0);
        check("midrst_busy", send_busy, 1'b0);
        check("midrst_header", sender_is_header, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        push_burst(); start_pulse(); wait_done(13, 1);
        idle(2);
        check("midrst_pkt_count", rx_pkt_count, 16'd2);

        // directed injection: index mismatch and short tail
        loop_en = 1'b0;
        do_reset();
        rx_send(1'b1, 1'b0, ctl(4'hA, 4'h5, 4'd5, 4'd6, 4'd1, 4'd2));
        rx_send(1'b0, 1'b0, pay(0, 0));
        rx_send(1'b0, 1'b0, pay(0, 2));
        rx_send(1'b0, 1'b1, ctl(4'hC, 4'h3, 4'd5, 4'd6, 4'd1, 4'd2));
        idle(2);
        check("inj_a_err", rx_err_count, CHK ? 16'd2 : 16'd0);
        check("inj_a_pkt", rx_pkt_count, 16'd1);
        check("inj_a_src", {rx_last_src_x, rx_last_src_y}, 8'h56);

        // directed injection: payload before any header
        do_reset();
        rx_send(1'b0, 1'b0, pay(0, 0));
        rx_send(1'b1, 1'b0, ctl(4'hA, 4'h5, 4'd7, 4'd3, 4'd1, 4'd2));
        for (int k = 0; k < PF; k++) rx_send(1'b0, 1'b0, pay(0, k));
        rx_send(1'b0, 1'b1, ctl(4'hC, 4'h3, 4'd7, 4'd3, 4'd1, 4'd2));
        idle(2);
        check("inj_b_err", rx_err_count, CHK ? 16'd1 : 16'd0);
        check("inj_b_pkt", rx_pkt_count, 16'd1);
        check("inj_b_src", {rx_last_src_x, rx_last_src_y}, 8'h73);

        // random injection
        for (int i = 0; i < 120; i++) begin
            r   = $urandom_range(0, 9);
            rx4 = 4'($urandom_range(0, 15));
            ry4 = 4'($urandom_range(0, 15));
            case (r)
                0, 1:    rx_send(1'b1, 1'b0, ctl(4'hA, 4'h5, rx4, ry4, 4'd0, 4'd0));
                2:       rx_send(1'b0, 1'b1, ctl(4'hC, 4'h3, rx4, ry4, 4'd0, 4'd0));
                3:       rx_send(1'b1, 1'b1, ctl(4'hA, 4'h3, rx4, ry4, 4'd0, 4'd0));
                default: rx_send(1'b0, 1'b0, pay($urandom_range(0, 3), $urandom_range(0, PF)));
            endcase
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
